// File: rtl/friscv_pkg.sv
// Shared helpers for the friscv RAM primitives.
package friscv_pkg;

  // Number of byte lanes needed to cover a word of w bits; the last lane may be partial
  function automatic int FRISCV_NB_LANES(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/friscv_ram_lane.sv
// Storage for one byte lane of friscv_ram_be: one write port, combinational read port.
// Zero-initialised at time zero when FRISCV_RAM_INIT_EN is defined.
module friscv_ram_lane #(
  parameter int ADDR_WIDTH = 8,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [LANE_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [LANE_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [LANE_WIDTH-1:0] mem [DEPTH];

`ifdef FRISCV_RAM_INIT_EN
  // Cache simulations rely on valid bits starting cleared
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end
`endif

  always_ff @(posedge aclk) begin
    if (wr_en) mem[addr_in] <= data_in;
  end

  assign data_out = mem[addr_out];

endmodule

// File: rtl/friscv_ram_be.sv
// Simple-dual-port RAM with per-byte write enables and optional registered read.
// Define FRISCV_RAM_INIT_EN to zero the contents at time zero (simulation only).
module friscv_ram_be
  import friscv_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int BE_EN      = 1,
  parameter int FFD_EN     = 0
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 wr_en,
  input  logic [FRISCV_NB_LANES(DATA_WIDTH)-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]                addr_in,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic [ADDR_WIDTH-1:0]                addr_out,
  output logic [DATA_WIDTH-1:0]                data_out
);

  localparam int NB_LANES = FRISCV_NB_LANES(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] rd_word;

  for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
    localparam int LO = gi * 8;
    localparam int LW = ((DATA_WIDTH - LO) >= 8) ? 8 : (DATA_WIDTH - LO);

    logic lane_we;

    // Memory is never reset, but writes are held off while reset is asserted
    assign lane_we = wr_en & aresetn & ((BE_EN != 0) ? wr_be[gi] : 1'b1);

    friscv_ram_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LANE_WIDTH (LW)
    ) u_lane (
      .aclk     (aclk),
      .wr_en    (lane_we),
      .addr_in  (addr_in),
      .data_in  (data_in[LO +: LW]),
      .addr_out (addr_out),
      .data_out (rd_word[LO +: LW])
    );
  end

  if (FFD_EN != 0) begin : g_ffd
    logic [DATA_WIDTH-1:0] data_out_reg;

    // Samples the pre-write word, giving read-before-write on address collisions
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) data_out_reg <= '0;
      else          data_out_reg <= rd_word;
    end

    assign data_out = data_out_reg;
  end else begin : g_comb
    assign data_out = rd_word;
  end

endmodule

// File: tb/tb_friscv_ram_be.sv
// Randomised bench for friscv_ram_be: three configurations driven in parallel against a word-level model.
module tb_friscv_ram_be;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [3:0]  addr_in;
  logic [31:0] data_in;
  logic [3:0]  addr_out;
  logic [31:0] dout_be;
  logic [18:0] dout_full;
  logic [31:0] dout_ffd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] ref_be   [16];
  logic [18:0] ref_full [16];
  logic [31:0] exp_ffd;

  always #5 aclk = ~aclk;

  friscv_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BE_EN(1), .FFD_EN(0)) dut_be (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in),
    .data_in(data_in), .addr_out(addr_out), .data_out(dout_be));

  friscv_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(19), .BE_EN(0), .FFD_EN(0)) dut_full (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_be(wr_be[2:0]), .addr_in(addr_in),
    .data_in(data_in[18:0]), .addr_out(addr_out), .data_out(dout_full));

  friscv_ram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BE_EN(1), .FFD_EN(1)) dut_ffd (
    .aclk(aclk), .aresetn(aresetn), .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in),
    .data_in(data_in), .addr_out(addr_out), .data_out(dout_ffd));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge: update the model the way the spec describes, then compare all three outputs
  task automatic step();
    logic [31:0] mask;
    exp_ffd = aresetn ? ref_be[addr_out] : 32'h0;
    if (wr_en && aresetn) begin
      mask = 32'h0;
      for (int b = 0; b < 4; b++) if (wr_be[b]) mask[b*8 +: 8] = 8'hFF;
      ref_be[addr_in]   = (ref_be[addr_in] & ~mask) | (data_in & mask);
      ref_full[addr_in] = data_in[18:0];
    end
    @(posedge aclk);
    #1;
    check("rd_comb_be", dout_be, ref_be[addr_out]);
    check("rd_comb_full", {13'h0, dout_full}, {13'h0, ref_full[addr_out]});
    check("rd_ffd", dout_ffd, exp_ffd);
    $display("t=%0t we=%0b be=%h wa=%0d wd=%h ra=%0d be_out=%h full_out=%h ffd_out=%h",
             $time, wr_en, wr_be, addr_in, data_in, addr_out, dout_be, dout_full, dout_ffd);
  endtask

  task automatic set_wr(input logic en, input logic [3:0] be, input logic [3:0] a, input logic [31:0] d);
    wr_en = en; wr_be = be; addr_in = a; data_in = d;
  endtask

  initial begin
    aresetn = 1'b0;
    set_wr(1'b0, 4'h0, 4'h0, 32'h0);
    addr_out = 4'h0;
    #2;
    check("reset_ffd_zero", dout_ffd, 32'h0);
    @(posedge aclk);
    #1;
    check("reset_ffd_hold", dout_ffd, 32'h0);
    aresetn = 1'b1;

    // Prefill every location with full-word writes so the model is fully defined
    for (int i = 0; i < 16; i++) begin
      set_wr(1'b1, 4'hF, 4'(i), $urandom);
      addr_out = 4'(i);
      step();
    end

    // Byte-enabled writes, combinational read
    set_wr(1'b1, 4'hF, 4'd3, 32'hDEADBEEF);
    addr_out = 4'd3;
    step();
    check("be_full_word", dout_be, 32'hDEADBEEF);
    set_wr(1'b1, 4'h5, 4'd3, 32'h11223344);
    step();
    check("be_partial", dout_be, 32'hDE22BE44);

    // wr_be ignored on the 19-bit full-word instance; all-zero enables are a no-op for the byte-enabled ones
    set_wr(1'b1, 4'h0, 4'd0, 32'h0007FFFF);
    addr_out = 4'd0;
    step();
    check("full_ignore_be", {13'h0, dout_full}, 32'h0007FFFF);

    // Read-during-write on the registered port
    set_wr(1'b1, 4'hF, 4'd2, 32'h000000A5);
    addr_out = 4'd2;
    step();
    set_wr(1'b0, 4'h0, 4'd0, 32'h0);
    step();
    check("ffd_new_after_2nd", dout_ffd, 32'h000000A5);
    addr_out = 4'd3;
    #1;
    check("ffd_addr_change_hold", dout_ffd, 32'h000000A5);
    step();
    check("ffd_addr_change_next", dout_ffd, 32'hDE22BE44);

    // Asynchronous reset mid-operation: output clears at once, writes are dropped
    aresetn = 1'b0;
    #1;
    check("ffd_async_clear", dout_ffd, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_wr(1'b1, 4'hF, 4'(i + 2), $urandom);
      addr_out = 4'(i + 2);
      step();
    end
    aresetn = 1'b1;
    set_wr(1'b0, 4'h0, 4'h0, 32'h0);
    addr_out = 4'd3;
    step();
    step();
    check("after_reset_keep", dout_ffd, 32'hDE22BE44);

    // Back-to-back random writes while the read address sweeps
    for (int i = 0; i < 200; i++) begin
      set_wr(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), $urandom);
      addr_out = 4'(i % 16);
      step();
    end
    set_wr(1'b0, 4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      addr_out = 4'(i);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
